// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and the future transmitter:
// oversampling constants, parity/state encodings and the baud divisor table.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int VOTE_FIRST  = 6;
  localparam int VOTE_LAST   = 11;
  localparam int VOTE_THRESH = 4;
  localparam int VOTE_AT     = VOTE_LAST + 1;
  localparam int DIV_W       = 9;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } rx_state_e;

  // Divisor minus one for a 50 MHz clock; unknown selections fall back to 9600.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
    case (sel)
      3'd1:    return 9'd162;
      3'd2:    return 9'd80;
      3'd3:    return 9'd53;
      3'd4:    return 9'd26;
      default: return 9'd324;
    endcase
  endfunction

  function automatic parity_e parity_decode(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Consumer-side handshake of the UART receiver: held word, status flags and ack.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] data_byte;
  logic                 rx_done;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_byte, rx_done, rx_valid, parity_err, frame_err, overrun,
    input  rx_ack
  );

  modport slave (
    input  data_byte, rx_done, rx_valid, parity_err, frame_err, overrun,
    output rx_ack
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: counts 0..div_i while enabled, pulses tick_o on wrap.
module uart_baud_tick #(
  parameter int DIV_W = 9
) (
  input  logic             mclk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == div_i);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (!en_i || tick_o) cnt_d = '0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge mclk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised 16x oversampling UART receiver with majority vote, parity/framing/overrun
// reporting and a held-valid/ack output handshake.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic            mclk,
  input  logic            rst_n,
  input  logic [2:0]      baud_set,
  input  logic [1:0]      parity_mode,
  input  logic            stop2,
  input  logic            rs232_rx,
  output logic            uart_state,
  uart_rx_param_if.master rx_if
);

  localparam int TCW = $clog2(OVERSAMPLE);

  logic                 sync1_q, sync2_q, prev_q, fall, start_frame;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     div_cfg_q;
  parity_e              par_q;
  logic                 stop2_q;
  logic                 tick_en, tick;
  logic [TCW-1:0]       tick_cnt_q;
  logic [2:0]           sum_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q, ferr_q;
  logic                 at_vote, at_end, in_window, voted, last_data, last_stop, complete;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q, valid_q, perr_out_q, ferr_out_q, ovr_q;

  // Synchronisers reset to the idle level so reset never manufactures a start edge.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rs232_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall        = prev_q & ~sync2_q;
  assign start_frame = (state_q == S_IDLE) && fall;

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      div_cfg_q <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
    end else if (start_frame) begin
      div_cfg_q <= baud_div(baud_set);
      par_q     <= parity_decode(parity_mode);
      stop2_q   <= stop2;
    end
  end

  assign tick_en = (state_q != S_IDLE);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .mclk   (mclk),
    .rst_n  (rst_n),
    .en_i   (tick_en),
    .div_i  (div_cfg_q),
    .tick_o (tick)
  );

  assign at_vote   = tick && (tick_cnt_q == TCW'(VOTE_AT));
  assign at_end    = tick && (tick_cnt_q == TCW'(OVERSAMPLE - 1));
  assign in_window = (tick_cnt_q >= TCW'(VOTE_FIRST)) && (tick_cnt_q <= TCW'(VOTE_LAST));
  assign voted     = (sum_q >= 3'(VOTE_THRESH));
  assign last_data = (bit_cnt_q == 4'(DATA_BITS - 1));
  assign last_stop = !stop2_q || stop_cnt_q;
  assign complete  = (state_q == S_STOP) && at_vote && last_stop;

  always_ff @(posedge mclk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (fall) state_d = S_START;
      S_START: begin
        if (at_vote && voted) state_d = S_IDLE;
        else if (at_end)      state_d = S_DATA;
      end
      S_DATA:   if (at_end && last_data) state_d = (par_q == PAR_NONE) ? S_STOP : S_PARITY;
      S_PARITY: if (at_end) state_d = S_STOP;
      S_STOP:   if (complete) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    uart_state = (state_q != S_IDLE);
  end

  // Per-frame bookkeeping is cleared whenever the receiver sits idle.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      sum_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (state_q == S_IDLE) begin
      tick_cnt_q <= '0;
      sum_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else if (tick) begin
      tick_cnt_q <= tick_cnt_q + TCW'(1);
      if (at_vote)        sum_q <= '0;
      else if (in_window) sum_q <= sum_q + {2'b00, sync2_q};
      case (state_q)
        S_DATA: begin
          if (at_vote) shift_q <= {voted, shift_q[DATA_BITS-1:1]};
          if (at_end)  bit_cnt_q <= last_data ? 4'd0 : bit_cnt_q + 4'd1;
        end
        S_PARITY: if (at_vote) perr_q <= (^shift_q) ^ voted ^ (par_q == PAR_ODD);
        S_STOP: begin
          if (at_vote && !voted) ferr_q <= 1'b1;
          if (at_end)            stop_cnt_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // An ack coinciding with completion consumes the old word, so no overrun is flagged.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      data_q     <= '0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      done_q <= complete;
      if (complete) begin
        data_q     <= shift_q;
        perr_out_q <= perr_q;
        ferr_out_q <= ferr_q | ~voted;
      end
      if (complete)                        valid_q <= 1'b1;
      else if (rx_if.rx_ack && valid_q)    valid_q <= 1'b0;
      if (complete && valid_q && !rx_if.rx_ack) ovr_q <= 1'b1;
      else if (rx_if.rx_ack && valid_q)         ovr_q <= 1'b0;
    end
  end

  assign rx_if.data_byte  = data_q;
  assign rx_if.rx_done    = done_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.parity_err = perr_out_q;
  assign rx_if.frame_err  = ferr_out_q;
  assign rx_if.overrun    = ovr_q;

endmodule
